// File: rtl/aes_key_schedule_ctrl.sv
// Iterative AES-128 key-expansion controller.
// Emits round keys 0..NR over a valid/ready stream. Each round uses one
// evaluation of an external combinational SubWord block.
module aes_key_schedule_ctrl #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic [31:0]  sub_in,
    input  logic [31:0]  sub_out,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    input  logic         key_ready,
    output logic         done
);

    localparam int unsigned WW = 32;
    localparam int unsigned IW = 4;
    localparam logic [IW-1:0] NR_IDX = IW'(NR);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WW-1:0] w0;
    logic [WW-1:0] w1;
    logic [WW-1:0] w2;
    logic [WW-1:0] w3;
    logic [WW-1:0] w0_nxt;
    logic [WW-1:0] w1_nxt;
    logic [WW-1:0] w2_nxt;
    logic [WW-1:0] w3_nxt;

    logic accept;
    logic last;
    logic load;
    logic busy_nxt;
    logic valid_nxt;
    logic done_nxt;

    // Round constant for the step round r -> r+1.
    function automatic logic [7:0] rcon(input logic [IW-1:0] idx);
        logic [7:0] r;
        case (idx)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    assign accept = (state == EMIT) && key_ready;
    assign last   = (round_idx == NR_IDX);
    assign load   = (state == IDLE) && start;

    // RotWord(w3) feeds the external SubWord block in every state.
    assign sub_in = {w3[23:0], w3[31:24]};

    assign round_key = {w0, w1, w2, w3};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (accept && last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state, registered below.
    always_comb begin
        busy_nxt  = 1'b0;
        valid_nxt = 1'b0;
        done_nxt  = 1'b0;
        case (state_nxt)
            EMIT: begin
                busy_nxt  = 1'b1;
                valid_nxt = 1'b1;
            end
            DONE: begin
                done_nxt = 1'b1;
            end
            default: begin
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // Control output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            key_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            busy      <= busy_nxt;
            key_valid <= valid_nxt;
            done      <= done_nxt;
        end
    end

    // Next round key words; the chain of XORs follows the AES expansion.
    always_comb begin
        w0_nxt = w0 ^ sub_out ^ {rcon(round_idx), 24'h000000};
        w1_nxt = w1 ^ w0_nxt;
        w2_nxt = w2 ^ w1_nxt;
        w3_nxt = w3 ^ w2_nxt;
    end

    // Key words and round index: load on start, advance on each non-final accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            w0        <= '0;
            w1        <= '0;
            w2        <= '0;
            w3        <= '0;
            round_idx <= '0;
        end else if (load) begin
            w0        <= key_in[127:96];
            w1        <= key_in[95:64];
            w2        <= key_in[63:32];
            w3        <= key_in[31:0];
            round_idx <= '0;
        end else if (accept && !last) begin
            w0        <= w0_nxt;
            w1        <= w1_nxt;
            w2        <= w2_nxt;
            w3        <= w3_nxt;
            round_idx <= round_idx + IW'(1);
        end
    end

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Directed testbench for aes_key_schedule_ctrl (NR=10 and NR=1 instances).
module tb_aes_key_schedule_ctrl;

    localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_ALT  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_ZERO = 128'h0;

    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic         clk = 1'b0;
    logic         rst;
    logic         start, start1;
    logic [127:0] key_in, key_in1;
    logic         key_ready, key_ready1;
    logic         busy, busy1;
    logic [31:0]  sub_in, sub_in1, sub_out, sub_out1;
    logic [127:0] round_key, round_key1;
    logic [3:0]   round_idx, round_idx1;
    logic         key_valid, key_valid1;
    logic         done, done1;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_FLAT[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    // FIPS-197 Appendix A.1 round keys for KEY_FIPS.
    function automatic logic [127:0] exp_key(input int i);
        case (i)
            0:  return 128'h2b7e151628aed2a6abf7158809cf4f3c;
            1:  return 128'ha0fafe1788542cb123a339392a6c7605;
            2:  return 128'hf2c295f27a96b9435935807a7359f67f;
            3:  return 128'h3d80477d4716fe3e1e237e446d7a883b;
            4:  return 128'hef44a541a8525b7fb671253bdb0bad00;
            5:  return 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
            6:  return 128'h6d88a37a110b3efddbf98641ca0093fd;
            7:  return 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
            8:  return 128'head27321b58dbad2312bf5607f8d292f;
            9:  return 128'hac7766f319fadc2128d12941575c006e;
            10: return 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
            default: return 128'h0;
        endcase
    endfunction

    assign sub_out  = sub_word(sub_in);
    assign sub_out1 = sub_word(sub_in1);

    aes_key_schedule_ctrl #(.NR(10)) dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in), .busy(busy),
        .sub_in(sub_in), .sub_out(sub_out), .round_key(round_key),
        .round_idx(round_idx), .key_valid(key_valid), .key_ready(key_ready),
        .done(done)
    );

    aes_key_schedule_ctrl #(.NR(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .key_in(key_in1), .busy(busy1),
        .sub_in(sub_in1), .sub_out(sub_out1), .round_key(round_key1),
        .round_idx(round_idx1), .key_valid(key_valid1), .key_ready(key_ready1),
        .done(done1)
    );

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1; key_in = KEY_FIPS; key_ready = 1'b1;
        start1 = 1'b1; key_in1 = KEY_FIPS; key_ready1 = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, key_valid, done} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: busy/valid/done=%b required 000", {busy, key_valid, done});
        end
        tests_run++;
        if (round_idx !== 4'd0 || round_key !== 128'h0) begin
            tests_failed++;
            $display("FAIL reset_data: idx=%0d key=%h required 0/0", round_idx, round_key);
        end
        tests_run++;
        if ({busy1, key_valid1, done1} !== 3'b000 || round_key1 !== 128'h0) begin
            tests_failed++;
            $display("FAIL reset_nr1: ctrl=%b key=%h required 000/0", {busy1, key_valid1, done1}, round_key1);
        end
        start = 1'b0; start1 = 1'b0; key_ready = 1'b0; key_ready1 = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (key_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_hold: valid=%b busy=%b required 0/0", key_valid, busy);
        end
    endtask

    // Full-speed sequence; optionally pulse start with another key mid-stream.
    task automatic test_sequence(input int glitch_at);
        @(negedge clk);
        start = 1'b1; key_in = KEY_FIPS; key_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; key_in = KEY_ALT;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL seq_busy: busy=%b required 1", busy);
        end
        for (int i = 0; i <= 10; i++) begin
            tests_run++;
            if (key_valid !== 1'b1 || round_idx !== 4'(i) || round_key !== exp_key(i)) begin
                tests_failed++;
                $display("FAIL seq_key%0d: valid=%b idx=%0d key=%h required 1/%0d/%h",
                         i, key_valid, round_idx, round_key, i, exp_key(i));
            end
            start = (i == glitch_at);
            @(negedge clk);
        end
        start = 1'b0;
        tests_run++;
        if ({done, busy, key_valid} !== 3'b100) begin
            tests_failed++;
            $display("FAIL seq_done: done/busy/valid=%b required 100", {done, busy, key_valid});
        end
        @(negedge clk);
        tests_run++;
        if ({done, busy, key_valid} !== 3'b000) begin
            tests_failed++;
            $display("FAIL seq_idle: done/busy/valid=%b required 000", {done, busy, key_valid});
        end
        key_ready = 1'b0;
    endtask

    task automatic test_stall();
        int  expi;
        bit  seen_done;
        bit  sub_checked;
        expi = 0; seen_done = 1'b0; sub_checked = 1'b0;
        @(negedge clk);
        start = 1'b1; key_in = KEY_FIPS; key_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
            if (key_valid === 1'b1) begin
                tests_run++;
                if (round_idx !== 4'(expi) || round_key !== exp_key(expi)) begin
                    tests_failed++;
                    $display("FAIL stall_key: idx=%0d key=%h required %0d/%h",
                             round_idx, round_key, expi, exp_key(expi));
                end
                if (!sub_checked) begin
                    sub_checked = 1'b1;
                    tests_run++;
                    if (sub_in !== 32'hcf4f3c09) begin
                        tests_failed++;
                        $display("FAIL stall_sub_in: got %h required cf4f3c09", sub_in);
                    end
                end
                key_ready = 1'($urandom_range(0, 1));
                if (key_ready) expi++;
            end else if (done === 1'b1) begin
                seen_done = 1'b1;
                key_ready = 1'b0;
            end else begin
                tests_run++;
                tests_failed++;
                $display("FAIL stall_bubble: valid=%b done=%b at key %0d required valid 1", key_valid, done, expi);
                key_ready = 1'b1;
            end
            @(negedge clk);
        end
        tests_run++;
        if (!seen_done || expi != 11) begin
            tests_failed++;
            $display("FAIL stall_count: done_seen=%0d keys=%0d required 1/11", seen_done, expi);
        end
        key_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk);
        start = 1'b1; key_in = KEY_FIPS; key_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        tests_run++;
        if (round_idx !== 4'd5 || round_key !== exp_key(5)) begin
            tests_failed++;
            $display("FAIL rstmid_pre: idx=%0d key=%h required 5/%h", round_idx, round_key, exp_key(5));
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if ({busy, key_valid, done} !== 3'b000 || round_idx !== 4'd0 || round_key !== 128'h0) begin
            tests_failed++;
            $display("FAIL rstmid_post: ctrl=%b idx=%0d key=%h required 000/0/0",
                     {busy, key_valid, done}, round_idx, round_key);
        end
        @(negedge clk);
        tests_run++;
        if (key_valid !== 1'b0 || round_idx !== 4'd0) begin
            tests_failed++;
            $display("FAIL rstmid_idle: valid=%b idx=%0d required 0/0", key_valid, round_idx);
        end
        start = 1'b1; key_in = KEY_FIPS; key_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (key_valid !== 1'b1 || round_idx !== 4'd0 || round_key !== exp_key(0)) begin
            tests_failed++;
            $display("FAIL rstmid_idx0: valid=%b idx=%0d key=%h required 1/0/%h",
                     key_valid, round_idx, round_key, exp_key(0));
        end
        key_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (round_idx !== 4'd1 || round_key !== exp_key(1)) begin
            tests_failed++;
            $display("FAIL rstmid_idx1: idx=%0d key=%h required 1/%h", round_idx, round_key, exp_key(1));
        end
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (done === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL rstmid_drain: done_seen=%0d required 1", seen);
        end
        key_ready = 1'b0;
    endtask

    task automatic test_zero_back_to_back();
        bit seen;
        @(negedge clk);
        start = 1'b1; key_in = KEY_ZERO; key_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (round_key !== 128'h0 || sub_in !== 32'h0) begin
            tests_failed++;
            $display("FAIL zero_idx0: key=%h sub_in=%h required 0/0", round_key, sub_in);
        end
        @(negedge clk);
        tests_run++;
        if (round_idx !== 4'd1 || round_key !== 128'h62636363626363636263636362636363) begin
            tests_failed++;
            $display("FAIL zero_idx1: idx=%0d key=%h required 1/62636363626363636263636362636363",
                     round_idx, round_key);
        end
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (done === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL zero_done: done_seen=%0d required 1", seen);
        end
        start = 1'b1; key_in = KEY_ALT; key_ready = 1'b0;
        @(negedge clk);
        tests_run++;
        if (key_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_start_ignored: valid=%b busy=%b required 0/0", key_valid, busy);
        end
        key_in = KEY_FIPS;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (key_valid !== 1'b1 || round_idx !== 4'd0 || round_key !== KEY_FIPS) begin
            tests_failed++;
            $display("FAIL b2b_start: valid=%b idx=%0d key=%h required 1/0/%h",
                     key_valid, round_idx, round_key, KEY_FIPS);
        end
        key_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (done === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL b2b_drain: done_seen=%0d required 1", seen);
        end
        key_ready = 1'b0;
    endtask

    task automatic test_nr1();
        @(negedge clk);
        start1 = 1'b1; key_in1 = KEY_FIPS; key_ready1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        tests_run++;
        if (key_valid1 !== 1'b1 || round_idx1 !== 4'd0 || round_key1 !== exp_key(0)) begin
            tests_failed++;
            $display("FAIL nr1_idx0: valid=%b idx=%0d key=%h required 1/0/%h",
                     key_valid1, round_idx1, round_key1, exp_key(0));
        end
        @(negedge clk);
        tests_run++;
        if (key_valid1 !== 1'b1 || round_idx1 !== 4'd1 || round_key1 !== exp_key(1)) begin
            tests_failed++;
            $display("FAIL nr1_idx1: valid=%b idx=%0d key=%h required 1/1/%h",
                     key_valid1, round_idx1, round_key1, exp_key(1));
        end
        @(negedge clk);
        tests_run++;
        if ({done1, busy1, key_valid1} !== 3'b100) begin
            tests_failed++;
            $display("FAIL nr1_done: done/busy/valid=%b required 100", {done1, busy1, key_valid1});
        end
        @(negedge clk);
        tests_run++;
        if ({done1, busy1, key_valid1} !== 3'b000) begin
            tests_failed++;
            $display("FAIL nr1_idle: done/busy/valid=%b required 000", {done1, busy1, key_valid1});
        end
        key_ready1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequence(-1);
        test_stall();
        test_sequence(3);
        test_reset_mid();
        test_zero_back_to_back();
        test_nr1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "timeout");
    end

endmodule
